pad_in_filter: RTL and testbench
================================

// Module: pad_in_filter
// PURPOSE
//  Conditions the pad input (in_o of the generic pad wrapper) before pinmux/peripheral use.
//  - Synchronizes the asynchronous pad input into clk_i with 2 flops.
//  - Optionally rejects glitches shorter than Cycles clocks.
//  - Produces a filtered level, one-cycle rise/fall pulses and a saturating glitch counter.
//  Instantiated once per input-capable pad, directly downstream of the pad wrapper.
// PARAMETERS
//  Cycles     4   consecutive identical synchronized samples needed to commit a new level; legal range 2..256
//  GlitchCntW 8   width of glitch counter; legal range 1..16
//  CntW       $clog2(Cycles+1)   localparam, width of stability counter
// PORTS
//  clk_i           in   1           clock
//  rst_i           in   1           reset, synchronous, active-high
//  in_i            in   1           raw pad input, asynchronous to clk_i
//  filter_en_i     in   1           1 = glitch filter active, 0 = bypass
//  glitch_clr_i    in   1           clears glitch_cnt_o
//  sync_o          out  1           2-flop synchronized input, unfiltered
//  stable_o        out  1           filtered level
//  rise_o          out  1           1-cycle pulse when stable_o goes 0->1
//  fall_o          out  1           1-cycle pulse when stable_o goes 1->0
//  glitch_cnt_o    out  GlitchCntW  rejected-glitch count, saturating
// BEHAVIOUR
//  Reset
//  - Synchronous on rst_i. All flops clear to 0: sync stages, candidate, counter, stable_o, edge pulses, glitch_cnt_o.
//  - rst_i mid-filter discards any pending transition.
//  - No pulse is generated on the first cycle after reset.
//  Synchronizer
//  - in_i -> q1 -> q2; sync_o = q2.
//  - A step on in_i before edge N appears on sync_o after edge N+1.
//  Filter (filter_en_i=1)
//  - Registers: cand (1b), cnt (CntW).
//  - sync_o != cand: cand<=sync_o, cnt<=1.
//  - sync_o == cand and cnt<Cycles: cnt<=cnt+1.
//  - cnt saturates at Cycles.
//  - stable_o<=cand on the edge where cnt==Cycles-1 and sync_o==cand (i.e. Cycles equal samples), if cand!=stable_o.
//  - Latency: in_i step to stable_o = Cycles+2 edges. Cycles=4: step before edge 1 -> stable_o high after edge 6.
//  Bypass (filter_en_i=0)
//  - stable_o<=sync_o every cycle (latency 3 edges).
//  - cand<=sync_o, cnt<=Cycles.
//  - No glitch counting.
//  filter_en_i 0->1
//  - Takes effect next edge. Because cand==stable_o and cnt==Cycles there, no spurious commit occurs.
//  filter_en_i 1->0
//  - A pending transition commits within the bypass latency.
//  Edges
//  - rise_o/fall_o registered from the stable_o change; asserted the cycle after stable_o changes, for exactly 1 cycle.
//  - Never both high.
//  Glitch counter
//  - Increment event: filter enabled, cand!=stable_o, cnt<Cycles, and sync_o!=cand (pending change aborted).
//  - Saturates at all-ones; never wraps.
//  - glitch_clr_i has priority over a simultaneous increment: result 0.
// STRUCTURE
//  - Sub-module prim_flop_2sync (Width=1, ResetValue=0) for q1/q2; it uses the synchronous active-high reset rst_i.
//  - Filter, edge detect and counter live in this module.
//  - Shared package pad_in_pkg holds:
//    - DefaultFilterCycles=4
//    - DefaultGlitchCntW=8
//    - typedef struct packed {stable, rise, fall} pad_in_evt_t, consumed by pinmux/gpio.
// TESTING
//  1. Reset: drive in_i=1, hold rst_i 3 cycles.
//     -> all outputs 0 during reset; after release stable_o rises after Cycles+2 edges, rise_o pulses once.
//  2. Cycles=4, filter on: in_i 0->1 before edge 1, held.
//     -> sync_o=1 after edge 2, stable_o=1 after edge 6, rise_o=1 only after edge 7.
//  3. Filter on: sync pulses high for 3 cycles, then low.
//     -> stable_o stays 0, no edge pulse, glitch_cnt_o 0->1.
//  4. Bypass: 1-cycle sync pulse.
//     -> stable_o follows, rise_o then fall_o pulse, glitch_cnt_o unchanged.
//  5. GlitchCntW=2: inject 5 glitches.
//     -> count 1,2,3,3,3. glitch_clr_i together with a 6th glitch -> 0.
//  6. Pending change, then rst_i pulses at cnt=2.
//     -> no commit; cand/cnt/stable_o all 0 after reset.

Source files
------------

// File: rtl/pad_in_pkg.sv
// Shared definitions for pad input conditioning: default filter sizing and the
// event bundle handed to pinmux/gpio.
package pad_in_pkg;

    localparam int DefaultFilterCycles = 4;
    localparam int DefaultGlitchCntW   = 8;

    typedef struct packed {
        logic stable;
        logic rise;
        logic fall;
    } pad_in_evt_t;

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-stage synchronizer for bringing an asynchronous signal into the clk domain.
module prim_flop_2sync #(
    parameter int              Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= ResetValue;
            q    <= ResetValue;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_in_filter.sv
// Pad input conditioning: synchronize, optionally reject short glitches, and
// report the filtered level with edge pulses and a saturating glitch count.
module pad_in_filter
    import pad_in_pkg::*;
#(
    parameter int Cycles     = DefaultFilterCycles,
    parameter int GlitchCntW = DefaultGlitchCntW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_i,
    input  logic                  filter_en_i,
    input  logic                  glitch_clr_i,
    output logic                  sync_o,
    output logic                  stable_o,
    output logic                  rise_o,
    output logic                  fall_o,
    output logic [GlitchCntW-1:0] glitch_cnt_o
);

    localparam int CntW = $clog2(Cycles + 1);
    localparam logic [CntW-1:0]       CntMax    = CntW'(Cycles);
    localparam logic [CntW-1:0]       CntCommit = CntW'(Cycles - 1);
    localparam logic [GlitchCntW-1:0] GlitchMax = '1;

    logic                  sync;
    logic                  cand;
    logic [CntW-1:0]       cnt;
    logic                  stable;
    logic                  stable_d;
    logic                  rise;
    logic                  fall;
    logic [GlitchCntW-1:0] glitch_cnt;
    logic                  changed;
    logic                  glitch;
    pad_in_evt_t           evt;

    prim_flop_2sync #(
        .Width      (1),
        .ResetValue (1'b0)
    ) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (in_i),
        .q   (sync)
    );

    assign changed = (sync != cand);
    // A pending level change that is abandoned before reaching Cycles samples.
    assign glitch  = filter_en_i && changed && (cand != stable) && (cnt < CntMax);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cand   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else if (!filter_en_i) begin
            cand   <= sync;
            cnt    <= CntMax;
            stable <= sync;
        end else if (changed) begin
            cand <= sync;
            cnt  <= CntW'(1);
        end else if (cnt < CntMax) begin
            cnt <= cnt + CntW'(1);
            if (cnt == CntCommit && cand != stable) begin
                stable <= cand;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stable_d <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            stable_d <= stable;
            rise     <= stable & ~stable_d;
            fall     <= ~stable & stable_d;
        end
    end

    // Clear wins over a simultaneous increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || glitch_clr_i) begin
            glitch_cnt <= '0;
        end else if (glitch && glitch_cnt != GlitchMax) begin
            glitch_cnt <= glitch_cnt + GlitchCntW'(1);
        end
    end

    assign evt          = '{stable: stable, rise: rise, fall: fall};
    assign sync_o       = sync;
    assign stable_o     = evt.stable;
    assign rise_o       = evt.rise;
    assign fall_o       = evt.fall;
    assign glitch_cnt_o = glitch_cnt;

endmodule

// File: tb/tb_pad_in_filter.sv
// Table-driven bench for pad_in_filter (Cycles=4, GlitchCntW=2); expected
// observations go through a scoreboard queue and are checked one edge later.
module tb_pad_in_filter;

    localparam int Cycles     = 4;
    localparam int GlitchCntW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pad;
    logic                  filter_en;
    logic                  glitch_clr;
    logic                  sync;
    logic                  stable;
    logic                  rise;
    logic                  fall;
    logic [GlitchCntW-1:0] glitch_cnt;

    typedef struct packed {
        logic                  sync;
        logic                  stable;
        logic                  rise;
        logic                  fall;
        logic [GlitchCntW-1:0] gcnt;
    } obs_t;

    typedef struct {
        logic  rst;
        logic  pad;
        logic  en;
        logic  clr;
        obs_t  exp;
        string name;
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pad_in_filter #(
        .Cycles     (Cycles),
        .GlitchCntW (GlitchCntW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_i         (pad),
        .filter_en_i  (filter_en),
        .glitch_clr_i (glitch_clr),
        .sync_o       (sync),
        .stable_o     (stable),
        .rise_o       (rise),
        .fall_o       (fall),
        .glitch_cnt_o (glitch_cnt)
    );

    function automatic obs_t mk(input bit s, input bit st, input bit r, input bit f, input int g);
        obs_t o;
        o.sync   = s;
        o.stable = st;
        o.rise   = r;
        o.fall   = f;
        o.gcnt   = GlitchCntW'(g);
        return o;
    endfunction

    task automatic add_row(input string n, input bit r, input bit p, input bit e, input bit c, input obs_t x);
        vec_t v;
        v.rst  = r;
        v.pad  = p;
        v.en   = e;
        v.clr  = c;
        v.exp  = x;
        v.name = n;
        vecs.push_back(v);
    endtask

    // Three-sample sync pulse: rejected on the 6th edge after it starts, then the filter settles.
    task automatic add_glitch(input string tag, input int gc_before, input int gc_after, input bit clr);
        for (int r = 0; r < 9; r++) begin
            add_row($sformatf("%s_r%0d", tag, r), 1'b0, (r < 3), 1'b1, (clr && r == 5),
                    mk((r >= 1 && r <= 3), 1'b0, 1'b0, 1'b0, (r >= 5) ? gc_after : gc_before));
        end
    endtask

    task automatic apply_stimulus(input bit r, input bit p, input bit e, input bit c, input obs_t x);
        rst        = r;
        pad        = p;
        filter_en  = e;
        glitch_clr = c;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string n);
        obs_t got;
        obs_t want;
        got = {sync, stable, rise, fall, glitch_cnt};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, got %b", n, got);
        end else begin
            want = sb.pop_front();
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL %s: got sync=%b stable=%b rise=%b fall=%b cnt=%0d, expected sync=%b stable=%b rise=%b fall=%b cnt=%0d",
                         n, got.sync, got.stable, got.rise, got.fall, got.gcnt,
                         want.sync, want.stable, want.rise, want.fall, want.gcnt);
            end
        end
        checks++;
        if (rise === 1'b1 && fall === 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_excl: got rise=%b fall=%b, expected not both high", n, rise, fall);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pad        = 1'b1;
        filter_en  = 1'b1;
        glitch_clr = 1'b0;

        // Reset held with pad high, then release: commit after Cycles+2 edges.
        for (int i = 0; i < 3; i++) add_row($sformatf("reset%0d", i), 1'b1, 1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0, 0));
        add_row("rise_e1", 0, 1, 1, 0, mk(0, 0, 0, 0, 0));
        add_row("rise_e2", 0, 1, 1, 0, mk(1, 0, 0, 0, 0));
        add_row("rise_e3", 0, 1, 1, 0, mk(1, 0, 0, 0, 0));
        add_row("rise_e4", 0, 1, 1, 0, mk(1, 0, 0, 0, 0));
        add_row("rise_e5", 0, 1, 1, 0, mk(1, 0, 0, 0, 0));
        add_row("rise_e6", 0, 1, 1, 0, mk(1, 1, 0, 0, 0));
        add_row("rise_e7", 0, 1, 1, 0, mk(1, 1, 1, 0, 0));
        add_row("rise_e8", 0, 1, 1, 0, mk(1, 1, 0, 0, 0));

        // Filtered falling step.
        add_row("fall_e1", 0, 0, 1, 0, mk(1, 1, 0, 0, 0));
        add_row("fall_e2", 0, 0, 1, 0, mk(0, 1, 0, 0, 0));
        add_row("fall_e3", 0, 0, 1, 0, mk(0, 1, 0, 0, 0));
        add_row("fall_e4", 0, 0, 1, 0, mk(0, 1, 0, 0, 0));
        add_row("fall_e5", 0, 0, 1, 0, mk(0, 1, 0, 0, 0));
        add_row("fall_e6", 0, 0, 1, 0, mk(0, 0, 0, 0, 0));
        add_row("fall_e7", 0, 0, 1, 0, mk(0, 0, 0, 1, 0));
        add_row("fall_e8", 0, 0, 1, 0, mk(0, 0, 0, 0, 0));

        // Glitches count 1,2,3 then saturate.
        add_glitch("glitch1", 0, 1, 1'b0);
        add_glitch("glitch2", 1, 2, 1'b0);
        add_glitch("glitch3", 2, 3, 1'b0);
        add_glitch("glitch4", 3, 3, 1'b0);
        add_glitch("glitch5", 3, 3, 1'b0);

        // Bypass: a one-cycle sync pulse passes straight through, counter untouched.
        add_row("byp0", 0, 0, 0, 0, mk(0, 0, 0, 0, 3));
        add_row("byp1", 0, 1, 0, 0, mk(0, 0, 0, 0, 3));
        add_row("byp2", 0, 0, 0, 0, mk(1, 0, 0, 0, 3));
        add_row("byp3", 0, 0, 0, 0, mk(0, 1, 0, 0, 3));
        add_row("byp4", 0, 0, 0, 0, mk(0, 0, 1, 0, 3));
        add_row("byp5", 0, 0, 0, 0, mk(0, 0, 0, 1, 3));
        add_row("byp6", 0, 0, 0, 0, mk(0, 0, 0, 0, 3));
        add_row("reen0", 0, 0, 1, 0, mk(0, 0, 0, 0, 3));
        add_row("reen1", 0, 0, 1, 0, mk(0, 0, 0, 0, 3));

        // Clear on the same edge as an increment yields zero, also from a non-saturated count.
        add_glitch("clrsat", 3, 0, 1'b1);
        add_glitch("glitch6", 0, 1, 1'b0);
        add_glitch("clrone", 1, 0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].rst, vecs[i].pad, vecs[i].en, vecs[i].clr, vecs[i].exp);
            check_output(vecs[i].name);
        end

        // Reset arriving while a change is pending (cnt=2) must discard it.
        apply_stimulus(0, 1, 1, 0, mk(0, 0, 0, 0, 0)); check_output("midrst_p0");
        apply_stimulus(0, 1, 1, 0, mk(1, 0, 0, 0, 0)); check_output("midrst_p1");
        apply_stimulus(0, 1, 1, 0, mk(1, 0, 0, 0, 0)); check_output("midrst_p2");
        apply_stimulus(0, 1, 1, 0, mk(1, 0, 0, 0, 0)); check_output("midrst_p3");
        apply_stimulus(1, 1, 1, 0, mk(0, 0, 0, 0, 0)); check_output("midrst_rst");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 0, 1, 0, mk(0, 0, 0, 0, 0));
            check_output($sformatf("midrst_post%0d", i));
        end

        // Dropping the filter with a change pending commits it through the bypass path.
        apply_stimulus(0, 1, 1, 0, mk(0, 0, 0, 0, 0)); check_output("dis_q0");
        apply_stimulus(0, 1, 1, 0, mk(1, 0, 0, 0, 0)); check_output("dis_q1");
        apply_stimulus(0, 1, 1, 0, mk(1, 0, 0, 0, 0)); check_output("dis_q2");
        apply_stimulus(0, 1, 0, 0, mk(1, 1, 0, 0, 0)); check_output("dis_q3");
        apply_stimulus(0, 1, 0, 0, mk(1, 1, 1, 0, 0)); check_output("dis_q4");
        apply_stimulus(0, 1, 1, 0, mk(1, 1, 0, 0, 0)); check_output("dis_q5");
        apply_stimulus(0, 1, 1, 0, mk(1, 1, 0, 0, 0)); check_output("dis_q6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
